// File: rtl/id_stage_pipe.sv
// MIPS decode stage with built-in ID/EX register: decodes logic/shift/LUI/LW,
// resolves operands with EX/MEM forwarding, and handles load-use bubbles, stall and flush.
module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int FWD_EN   = 1,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inst_valid_in,
   input  logic [31:0]         inst_data_in,
   input  logic                stall_in,
   input  logic                flush_in,
   output logic [4:0]          reg_rd_addr1_out,
   output logic [4:0]          reg_rd_addr2_out,
   output logic                reg_rd_en1_out,
   output logic                reg_rd_en2_out,
   input  logic [DATA_W-1:0]   reg_rd_data1_in,
   input  logic [DATA_W-1:0]   reg_rd_data2_in,
   input  logic                ex_wr_en_in,
   input  logic [4:0]          ex_wr_addr_in,
   input  logic [DATA_W-1:0]   ex_wr_data_in,
   input  logic                ex_is_load_in,
   input  logic                mem_wr_en_in,
   input  logic [4:0]          mem_wr_addr_in,
   input  logic [DATA_W-1:0]   mem_wr_data_in,
   output logic                stall_req_out,
   output logic                ex_valid_out,
   output logic [ALUOP_W-1:0]  aluop_out,
   output logic [ALUSEL_W-1:0] alusel_out,
   output logic [DATA_W-1:0]   opnd1_out,
   output logic [DATA_W-1:0]   opnd2_out,
   output logic [4:0]          wr_addr_out,
   output logic                wr_en_out,
   output logic                inst_invalid_out
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] FN_SLL     = 6'b000000;
   localparam logic [5:0] FN_AND     = 6'b100100;
   localparam logic [5:0] FN_OR      = 6'b100101;
   localparam logic [5:0] FN_XOR     = 6'b100110;
   localparam logic [5:0] FN_NOR     = 6'b100111;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;

   assign op    = inst_data_in[31:26];
   assign rs    = inst_data_in[25:21];
   assign rt    = inst_data_in[20:16];
   assign rd    = inst_data_in[15:11];
   assign shamt = inst_data_in[10:6];
   assign funct = inst_data_in[5:0];
   assign imm   = inst_data_in[15:0];

   logic                use1, use2;
   logic [DATA_W-1:0]   imm1, imm2;
   logic [ALUOP_W-1:0]  dec_aluop;
   logic [ALUSEL_W-1:0] dec_alusel;
   logic [4:0]          dec_dest;
   logic                dec_wr, dec_invalid;

   always_comb begin
      use1        = 1'b0;
      use2        = 1'b0;
      imm1        = '0;
      imm2        = '0;
      dec_aluop   = '0;
      dec_alusel  = '0;
      dec_dest    = 5'd0;
      dec_wr      = 1'b0;
      dec_invalid = 1'b0;
      case (op)
         OP_ORI, OP_ANDI, OP_XORI: begin
            use1       = 1'b1;
            imm2       = DATA_W'(imm);
            dec_alusel = ALUSEL_W'(1);
            dec_dest   = rt;
            dec_wr     = 1'b1;
            dec_aluop  = (op == OP_ANDI) ? ALUOP_W'(8'h24) :
                         (op == OP_XORI) ? ALUOP_W'(8'h26) : ALUOP_W'(8'h25);
         end
         OP_LUI: begin
            imm2       = DATA_W'({imm, 16'h0000});
            dec_aluop  = ALUOP_W'(8'h25);
            dec_alusel = ALUSEL_W'(1);
            dec_dest   = rt;
            dec_wr     = 1'b1;
         end
         OP_LW: begin
            use1       = 1'b1;
            imm2       = DATA_W'($signed(imm));
            dec_aluop  = ALUOP_W'(8'hE3);
            dec_alusel = ALUSEL_W'(3);
            dec_dest   = rt;
            dec_wr     = 1'b1;
         end
         OP_SPECIAL: begin
            case (funct)
               FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                  // logic funct codes coincide with their aluop encodings
                  use1       = 1'b1;
                  use2       = 1'b1;
                  dec_aluop  = ALUOP_W'({2'b00, funct});
                  dec_alusel = ALUSEL_W'(1);
                  dec_dest   = rd;
                  dec_wr     = 1'b1;
               end
               FN_SLL: begin
                  use2       = 1'b1;
                  imm1       = DATA_W'(shamt);
                  dec_aluop  = ALUOP_W'(8'h7C);
                  dec_alusel = ALUSEL_W'(2);
                  dec_dest   = rd;
                  dec_wr     = 1'b1;
               end
               default: dec_invalid = 1'b1;
            endcase
         end
         default: dec_invalid = 1'b1;
      endcase
   end

   assign reg_rd_en1_out   = inst_valid_in & use1;
   assign reg_rd_en2_out   = inst_valid_in & use2;
   assign reg_rd_addr1_out = reg_rd_en1_out ? rs : 5'd0;
   assign reg_rd_addr2_out = reg_rd_en2_out ? rt : 5'd0;

   function automatic logic [DATA_W-1:0] resolve(
      input logic [4:0]        addr,
      input logic [DATA_W-1:0] rf_data,
      input logic              ex_we,
      input logic [4:0]        ex_a,
      input logic [DATA_W-1:0] ex_d,
      input logic              mem_we,
      input logic [4:0]        mem_a,
      input logic [DATA_W-1:0] mem_d
   );
      if (addr == 5'd0)                          return '0;
      else if (FWD_EN != 0 && ex_we && ex_a == addr)   return ex_d;
      else if (FWD_EN != 0 && mem_we && mem_a == addr) return mem_d;
      else                                       return rf_data;
   endfunction

   logic [DATA_W-1:0] opnd1, opnd2;

   always_comb begin
      opnd1 = reg_rd_en1_out
              ? resolve(reg_rd_addr1_out, reg_rd_data1_in, ex_wr_en_in, ex_wr_addr_in,
                        ex_wr_data_in, mem_wr_en_in, mem_wr_addr_in, mem_wr_data_in)
              : imm1;
      opnd2 = reg_rd_en2_out
              ? resolve(reg_rd_addr2_out, reg_rd_data2_in, ex_wr_en_in, ex_wr_addr_in,
                        ex_wr_data_in, mem_wr_en_in, mem_wr_addr_in, mem_wr_data_in)
              : imm2;
   end

   // a load in EX cannot be forwarded in time, so the dependent instruction must wait
   assign stall_req_out = inst_valid_in & ex_wr_en_in & ex_is_load_in & (ex_wr_addr_in != 5'd0) &
                          ((reg_rd_en1_out & (reg_rd_addr1_out == ex_wr_addr_in)) |
                           (reg_rd_en2_out & (reg_rd_addr2_out == ex_wr_addr_in)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush_in) begin
         ex_valid_out     <= 1'b0;
         aluop_out        <= '0;
         alusel_out       <= '0;
         opnd1_out        <= '0;
         opnd2_out        <= '0;
         wr_addr_out      <= 5'd0;
         wr_en_out        <= 1'b0;
         inst_invalid_out <= 1'b0;
      end else if (stall_in) begin
         ex_valid_out     <= ex_valid_out;
      end else if (stall_req_out || !inst_valid_in) begin
         ex_valid_out     <= 1'b0;
         aluop_out        <= '0;
         alusel_out       <= '0;
         opnd1_out        <= '0;
         opnd2_out        <= '0;
         wr_addr_out      <= 5'd0;
         wr_en_out        <= 1'b0;
         inst_invalid_out <= 1'b0;
      end else begin
         ex_valid_out     <= 1'b1;
         aluop_out        <= dec_aluop;
         alusel_out       <= dec_alusel;
         opnd1_out        <= opnd1;
         opnd2_out        <= opnd2;
         wr_addr_out      <= dec_dest;
         wr_en_out        <= dec_wr & (dec_dest != 5'd0);
         inst_invalid_out <= dec_invalid;
      end
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised MIPS decode stage with the ID/EX pipeline register built in.
- Decodes logic-immediate, R-type logic/shift, LUI and LW instructions.
- Reads operands from the register file and forwards results from the EX and MEM stages.
- Detects load-use hazards and inserts bubbles. Supports downstream stall and pipeline flush.

Parameters:
- DATA_W, 32, datapath width (>=32); immediates extend to DATA_W.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = operands come from the register file only.
- ALUOP_W, 8, aluop field width.
- ALUSEL_W, 3, alusel field width.

Ports:
- clk  in  1  stage clock.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_valid_in  in  1  IF/ID holds a valid instruction.
- inst_data_in  in  32  instruction word.
- stall_in  in  1  downstream stall; hold the ID/EX register.
- flush_in  in  1  kill the current instruction; load a bubble.
- reg_rd_addr1_out / reg_rd_addr2_out  out  5  register-file read addresses (rs/rt), combinational.
- reg_rd_en1_out / reg_rd_en2_out  out  1  read enables, combinational.
- reg_rd_data1_in / reg_rd_data2_in  in  DATA_W  register-file read data.
- ex_wr_en_in, ex_wr_addr_in[4:0], ex_wr_data_in[DATA_W], ex_is_load_in  in  EX-stage result and load flag.
- mem_wr_en_in, mem_wr_addr_in[4:0], mem_wr_data_in[DATA_W]  in  MEM-stage result.
- stall_req_out  out  1  load-use stall request to IF/ID, combinational.
- ex_valid_out  out  1  ID/EX holds a valid instruction.
- aluop_out  out  ALUOP_W  ALU operation.
- alusel_out  out  ALUSEL_W  result class.
- opnd1_out / opnd2_out  out  DATA_W  resolved operands.
- wr_addr_out  out  5  destination register.
- wr_en_out  out  1  writeback enable.
- inst_invalid_out  out  1  undecodable opcode/funct, registered.

Behaviour:
- Decode table (op/funct -> aluop, alusel, opnd1, opnd2, dest):
  - ORI 001101 / ANDI 001100 / XORI 001110 -> aluop OR 0x25 / AND 0x24 / XOR 0x26; alusel LOGIC 1; opnd1 = rs; opnd2 = zero-extended imm16; dest rt.
  - LUI 001111 -> aluop OR 0x25; alusel LOGIC 1; opnd1 = 0; opnd2 = imm16<<16, zero-extended; dest rt.
  - SPECIAL 000000, funct 100101/100100/100110/100111 -> OR/AND/XOR/NOR (0x25/0x24/0x26/0x27); alusel LOGIC 1; opnd1 = rs; opnd2 = rt; dest rd.
  - SPECIAL 000000, funct 000000 (SLL) -> aluop 0x7C; alusel SHIFT 2; opnd1 = shamt zero-extended; opnd2 = rt; dest rd.
  - LW 100011 -> aluop 0xE3; alusel LOAD 3; opnd1 = rs; opnd2 = sign-extended imm16; dest rt.
  - Anything else -> aluop NOP 0x00; alusel NOP 0; wr_en 0; inst_invalid 1.
- Read enables: asserted only for register operands actually used. Unused ports drive addr 0, en 0.
- Operand resolution per enabled port, in priority order:
  - address 0 -> 0.
  - FWD_EN and ex_wr_en_in and address match -> ex_wr_data_in.
  - FWD_EN and mem_wr_en_in and address match -> mem_wr_data_in.
  - otherwise register-file data.
- Writes with dest 0 set wr_en 0.
- stall_req_out = inst_valid_in & ex_wr_en_in & ex_is_load_in & (ex_wr_addr_in != 0) & (ex_wr_addr_in matches any enabled read address). It is asserted regardless of FWD_EN.
- ID/EX register update on each rising clk edge, first match wins:
  - flush_in -> bubble (ex_valid 0, wr_en 0, aluop/alusel NOP, operands 0, inst_invalid 0).
  - stall_in -> hold all outputs.
  - stall_req_out -> bubble.
  - otherwise load the decoded fields; ex_valid_out = inst_valid_in.
- An invalid slot (inst_valid_in = 0) loads as a bubble with inst_invalid 0.
- Latency: exactly 1 cycle from a valid instruction to ex_valid_out.
- Simultaneous flush_in and stall_in -> flush wins.
- Simultaneous stall_in and stall_req_out -> hold. stall_req_out still drives IF/ID.
- Reset: rst_n low asynchronously clears every registered output to 0 (ex_valid 0, wr_en 0, aluop/alusel NOP, operands 0, wr_addr 0, inst_invalid 0). Combinational outputs follow inputs.
- Reset asserted mid-stall discards the held instruction.

Test Plan:
- Reset then ORI $3,$1,0x00F0 with $1 = 0x0000_0F00 -> next cycle ex_valid 1, aluop 0x25, alusel 1, opnd1 0x0F00, opnd2 0x00F0, wr_addr 3, wr_en 1.
- LW $2,-4($5), then ex_is_load_in=1, ex_wr_addr_in=2, followed by OR $4,$2,$6 -> stall_req_out 1 for one cycle, one bubble issued, then OR issues with MEM-forwarded $2 data.
- EX writes $7=0xAAAA_0000 while MEM writes $7=0x1111_1111, then AND $8,$7,$7 -> both operands 0xAAAA_0000 (EX priority). With FWD_EN=0 -> register-file value.
- LUI $9,0x1234 -> opnd2 0x1234_0000. SLL $10,$11,5 -> opnd1 5, alusel 2. ORI $0,$1,1 -> wr_en 0.
- stall_in held 3 cycles with a new instruction present -> outputs unchanged. flush_in together with stall_in -> bubble next edge.
- Opcode 111111 -> inst_invalid_out 1, wr_en 0. rst_n pulsed low between clock edges -> all registered outputs 0 immediately.
